// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch stage
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter flop with synchronous reset and load enable
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch stage: PC, imem req/ack handshake, instruction hand-off to decode
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_inc,
  output logic [XLEN-1:0] instr_out,
  output logic            instr_valid,
  input  logic            instr_ready
);

  fetch_state_t state;
  logic         active;
  logic         flush_eff;
  logic         accept;
  logic [XLEN-1:0] pc;

  // Flush only counts once the fetch loop is running; IDLE ignores it.
  assign active    = (state == REQ) || (state == HOLD);
  assign flush_eff = flush && active;
  assign accept    = instr_valid && instr_ready && !stall && (state == HOLD);

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .load(accept || flush_eff),
    .d   (next_pc),
    .q   (pc)
  );

  assign pc_out    = pc;
  assign imem_addr = pc;
  assign pc_inc    = pc + XLEN'(PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state       <= REQ;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
        REQ: begin
          if (flush_eff) begin
            state       <= REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end else if (imem_ack) begin
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            instr_out   <= imem_rdata;
          end
        end
        HOLD: begin
          if (flush_eff || accept) begin
            state       <= REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
